// File: rtl/datapath_unit_pkg.sv
// Shared definitions for the datapath unit: default widths, opcodes, selmux codes,
// instruction field layout and an instruction builder.
package datapath_unit_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned PC_W_DEF   = 6;
    localparam int unsigned OP_W       = 2;

    // Instruction layout {op, a, b}, offsets for the default address width
    localparam int unsigned INSTR_W_DEF = OP_W + 2 * ADDR_W_DEF;
    localparam int unsigned B_LSB_DEF   = 0;
    localparam int unsigned A_LSB_DEF   = ADDR_W_DEF;
    localparam int unsigned OP_LSB_DEF  = 2 * ADDR_W_DEF;

    typedef enum logic [OP_W-1:0] {
        OP_SUM = 2'b00,
        OP_RES = 2'b01,
        OP_MOV = 2'b10,
        OP_OUT = 2'b11
    } opcode_e;

    // Address/data select codes; any other value addresses field a
    localparam logic [2:0] SM_A      = 3'd1;
    localparam logic [2:0] SM_B      = 3'd2;
    localparam logic [2:0] SM_WR_ALU = 3'd3;

    // Pack an instruction word for the default geometry
    function automatic logic [INSTR_W_DEF-1:0] make_instr(
        input opcode_e               op,
        input logic [ADDR_W_DEF-1:0] a,
        input logic [ADDR_W_DEF-1:0] b
    );
        logic [INSTR_W_DEF-1:0] w;
        w = '0;
        w[OP_LSB_DEF +: OP_W]      = op;
        w[A_LSB_DEF  +: ADDR_W_DEF] = a;
        w[B_LSB_DEF  +: ADDR_W_DEF] = b;
        return w;
    endfunction

endpackage

// File: rtl/datapath_unit_alu_sumres.sv
// Add/subtract ALU with carry-out on add and borrow-out on subtract.
module datapath_unit_alu_sumres #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] res_c_o,
    output logic              carry_c_o
);

    logic [DATA_W:0] ext_c;

    // One extra bit holds the add carry, or the subtract borrow (set when op1 < op2)
    always_comb begin
        ext_c = '0;
        if (sub_i) begin
            ext_c = {1'b0, op1_i} - {1'b0, op2_i};
        end else begin
            ext_c = {1'b0, op1_i} + {1'b0, op2_i};
        end
    end

    assign res_c_o   = ext_c[DATA_W-1:0];
    assign carry_c_o = ext_c[DATA_W];

endmodule

// File: rtl/datapath_unit.sv
// Datapath steered by an external control FSM: PC, instruction register, data memory,
// operand registers, add/sub ALU, output register and carry flag.
module datapath_unit
    import datapath_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OP_W+2*ADDR_W-1:0]   instr_in,
    input  logic                       enmem,
    input  logic                       enir,
    input  logic                       enrop1,
    input  logic                       enrop2,
    input  logic                       enrio,
    input  logic                       enpc,
    input  logic                       seloper,
    input  logic [2:0]                 selmux,
    input  logic                       ld_en,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    output logic [PC_W-1:0]            pc,
    output logic [1:0]                 operacion,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic                       carry
);

    localparam int unsigned INSTR_W = OP_W + 2 * ADDR_W;
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned A_LSB   = ADDR_W;
    localparam int unsigned OP_LSB  = 2 * ADDR_W;

    logic [PC_W-1:0]    pc_q,    pc_d;
    logic [INSTR_W-1:0] ir_q,    ir_d;
    logic [DATA_W-1:0]  op1_q,   op1_d;
    logic [DATA_W-1:0]  op2_q,   op2_d;
    logic               sub_q,   sub_d;
    logic [DATA_W-1:0]  out_q,   out_d;
    logic               ov_q,    ov_d;
    logic               carry_q, carry_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0]  field_a_c;
    logic [ADDR_W-1:0]  field_b_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [DATA_W-1:0]  rd_data_c;
    logic               wr_alu_c;
    logic [ADDR_W-1:0]  wr_addr_c;
    logic [DATA_W-1:0]  wr_data_c;
    logic [DATA_W-1:0]  alu_res_c;
    logic               alu_carry_c;

    assign field_a_c = ir_q[A_LSB +: ADDR_W];
    assign field_b_c = ir_q[0 +: ADDR_W];

    // Read port address: field b only when explicitly selected
    always_comb begin
        rd_addr_c = field_a_c;
        case (selmux)
            SM_A:    rd_addr_c = field_a_c;
            SM_B:    rd_addr_c = field_b_c;
            default: rd_addr_c = field_a_c;
        endcase
    end

    assign rd_data_c = mem_q[rd_addr_c];

    // Write-back path: ALU result to field a, otherwise op1 copied to field b
    assign wr_alu_c  = (selmux == SM_WR_ALU);
    assign wr_addr_c = wr_alu_c ? field_a_c : field_b_c;
    assign wr_data_c = wr_alu_c ? alu_res_c : op1_q;

    datapath_unit_alu_sumres #(
        .DATA_W (DATA_W)
    ) u_alu_sumres (
        .op1_i     (op1_q),
        .op2_i     (op2_q),
        .sub_i     (sub_q),
        .res_c_o   (alu_res_c),
        .carry_c_o (alu_carry_c)
    );

    // Data memory: not reset; datapath write beats preload, preload still works under reset
    always_ff @(posedge clk) begin
        if (enmem && !rst) begin
            mem_q[wr_addr_c] <= wr_data_c;
        end else if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // Next-state for every register; each enable acts on its own register only
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sub_d   = sub_q;
        out_d   = out_q;
        ov_d    = 1'b0;
        carry_d = carry_q;

        if (enpc) begin
            pc_d = pc_q + PC_W'(1);
        end
        if (enir) begin
            ir_d = instr_in;
        end
        if (enrop1) begin
            op1_d = rd_data_c;
        end
        if (enrop2) begin
            op2_d = rd_data_c;
            sub_d = seloper;
        end
        if (enrio) begin
            out_d = rd_data_c;
            ov_d  = 1'b1;
        end
        if (enmem && wr_alu_c) begin
            carry_d = alu_carry_c;
        end
    end

    // Register bank with synchronous reset overriding all enables
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sub_q   <= 1'b0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sub_q   <= sub_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            carry_q <= carry_d;
        end
    end

    assign pc        = pc_q;
    assign operacion = ir_q[OP_LSB +: OP_W];
    assign out_data  = out_q;
    assign out_valid = ov_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: drives FSM-like enable sequences per instruction,
// keeps an instruction-level model and compares outputs on every settled cycle.
module tb_datapath_unit;
    import datapath_unit_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned PW = 6;
    localparam int unsigned IW = 2 + 2 * AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instr_in;
    logic          enmem, enir, enrop1, enrop2, enrio, enpc, seloper;
    logic [2:0]    selmux;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [PW-1:0] pc;
    logic [1:0]    operacion;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          carry;

    logic [IW-1:0] rom [64];

    // Instruction-level model state
    int m_mem [8];
    int m_pc, m_op, m_out, m_ov, m_carry;
    bit chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign instr_in = rom[pc];

    datapath_unit dut (
        .clk       (clk),
        .rst       (rst),
        .instr_in  (instr_in),
        .enmem     (enmem),
        .enir      (enir),
        .enrop1    (enrop1),
        .enrop2    (enrop2),
        .enrio     (enrio),
        .enpc      (enpc),
        .seloper   (seloper),
        .selmux    (selmux),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .pc        (pc),
        .operacion (operacion),
        .out_data  (out_data),
        .out_valid (out_valid),
        .carry     (carry)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model whenever the model is current
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", int'(pc), m_pc);
            check("operacion", int'(operacion), m_op);
            check("out_data", int'(out_data), m_out);
            check("out_valid", int'(out_valid), m_ov);
            check("carry", int'(carry), m_carry);
        end
    end

    task automatic idle_in();
        enmem = 0; enir = 0; enrop1 = 0; enrop2 = 0; enrio = 0; enpc = 0;
        seloper = 0; selmux = 3'd0; ld_en = 0; ld_addr = '0; ld_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 0; m_op = 0; m_out = 0; m_ov = 0; m_carry = 0;
    endtask

    task automatic preload(input int addr, input int data);
        ld_en = 1; ld_addr = AW'(addr); ld_data = DW'(data);
        tick();
        ld_en = 0;
        m_mem[addr] = data;
    endtask

    // Runs one instruction through its control sequence; optional preload collision on write-back
    task automatic run_instr(input opcode_e op, input int a, input int b,
                             input bit coll, input int coll_data);
        chk_en = 0;
        rom[m_pc] = make_instr(op, AW'(a), AW'(b));
        idle_in(); enir = 1; enpc = 1;                  // F
        tick();
        idle_in();                                       // D
        tick();
        case (op)
            OP_SUM, OP_RES: begin
                enrop1 = 1; selmux = SM_A; tick(); idle_in();
                enrop2 = 1; selmux = SM_B; seloper = (op == OP_RES); tick(); idle_in();
                enmem = 1; selmux = SM_WR_ALU; seloper = 0; tick(); idle_in();
            end
            OP_MOV: begin
                enrop1 = 1; selmux = SM_A; tick(); idle_in();
                enmem = 1; selmux = SM_B;
                if (coll) begin
                    ld_en = 1; ld_addr = AW'(b); ld_data = DW'(coll_data);
                end
                tick(); idle_in();
            end
            default: begin
                enrio = 1; selmux = SM_A; tick(); idle_in();
            end
        endcase
        // Architectural effect of the instruction
        m_pc = (m_pc + 1) % 64;
        m_op = int'(op);
        m_ov = 0;
        case (op)
            OP_SUM: begin
                m_carry = ((m_mem[a] + m_mem[b]) > 255) ? 1 : 0;
                m_mem[a] = (m_mem[a] + m_mem[b]) % 256;
            end
            OP_RES: begin
                m_carry = (m_mem[a] < m_mem[b]) ? 1 : 0;
                m_mem[a] = (m_mem[a] - m_mem[b] + 256) % 256;
            end
            OP_MOV: m_mem[b] = m_mem[a];
            default: begin
                m_out = m_mem[a];
                m_ov  = 1;
            end
        endcase
        chk_en = 1;
        tick();                                          // COU
        m_ov = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = '0;
        for (int i = 0; i < 8; i++) m_mem[i] = 0;
        model_reset();
        idle_in();
        rst = 1;
        tick();
        tick();

        // Preload under reset, then hammer every enable while reset is still high
        preload(7, 8'h33);
        enmem = 1; selmux = SM_WR_ALU; enir = 1; enpc = 1; enrop1 = 1; enrop2 = 1;
        enrio = 1; seloper = 1;
        tick();
        idle_in();
        rst = 0;
        model_reset();
        chk_en = 1;
        check("rst_pc_lit", int'(pc), 0);
        check("rst_out_lit", int'(out_data), 0);
        check("rst_carry_lit", int'(carry), 0);
        check("rst_ov_lit", int'(out_valid), 0);
        tick();

        preload(0, 8'h5A);
        preload(1, 200);
        preload(2, 100);
        preload(3, 5);
        preload(4, 9);
        preload(5, 3);
        preload(6, 4);

        run_instr(OP_OUT, 7, 0, 0, 0);
        check("rst_mem_kept_lit", m_out, 8'h33);

        // SUM with carry: 200 + 100 = 300 -> 44
        run_instr(OP_SUM, 1, 2, 0, 0);
        check("sum_carry_lit", int'(carry), 1);
        run_instr(OP_OUT, 1, 0, 0, 0);
        check("sum_res_lit", int'(out_data), 44);
        check("sum_pc_lit", int'(pc), 3);

        // RES with borrow: 5 - 9 -> 252
        run_instr(OP_RES, 3, 4, 0, 0);
        check("res_carry_lit", int'(carry), 1);
        run_instr(OP_OUT, 3, 0, 0, 0);
        check("res_res_lit", int'(out_data), 252);

        // SUM without carry, RES without borrow
        run_instr(OP_SUM, 5, 6, 0, 0);
        check("sum_nocarry_lit", int'(carry), 0);
        run_instr(OP_RES, 4, 6, 0, 0);
        run_instr(OP_OUT, 4, 0, 0, 0);
        check("res_noborrow_lit", int'(out_data), 5);

        // MOV then OUT through the moved location
        run_instr(OP_MOV, 0, 6, 0, 0);
        run_instr(OP_OUT, 6, 0, 0, 0);
        check("mov_out_lit", int'(out_data), 8'h5A);

        // Write-back and preload collide on the same address: datapath wins
        run_instr(OP_MOV, 1, 2, 1, 8'hEE);
        run_instr(OP_OUT, 2, 0, 0, 0);
        check("collision_lit", int'(out_data), 44);

        // Reset keeps memory; PC wraps after 64 increments
        chk_en = 0;
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        chk_en = 1;
        for (int i = 0; i < 63; i++) begin
            enpc = 1;
            tick();
            m_pc = (m_pc + 1) % 64;
        end
        check("pc_max_lit", int'(pc), 63);
        tick();
        m_pc = 0;
        enpc = 0;
        check("pc_wrap_lit", int'(pc), 0);

        // enir and enpc together: IR takes the instruction at the old PC
        rom[0] = make_instr(OP_OUT, 3'd0, 3'd0);
        rom[1] = make_instr(OP_MOV, 3'd0, 3'd0);
        enir = 1; enpc = 1;
        tick();
        idle_in();
        m_pc = 1;
        m_op = int'(OP_OUT);
        check("ir_oldpc_lit", int'(operacion), 3);
        tick();

        run_instr(OP_OUT, 3, 0, 0, 0);
        check("mem_after_rst_lit", int'(out_data), 252);
        tick();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
